// File: rtl/play_stream_engine.sv
// SDRAM clip streamer: prefetches a bounded word region into a small FIFO and feeds the audio sink.
// Optional build macro PLAY_LOOP_EN adds a play_loop input for seamless clip repetition.
module play_stream_engine #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              play_start,
  input  logic [ADDR_W-1:0] play_select,
  input  logic [LEN_W-1:0]  play_length,
  input  logic [1:0]        play_speed,
  input  logic              play_pause,
  input  logic              play_stop,
`ifdef PLAY_LOOP_EN
  input  logic              play_loop,
`endif
  output logic              play_done,
  output logic              play_busy,
  output logic              play_read,
  output logic [ADDR_W-1:0] play_addr,
  input  logic [DATA_W-1:0] play_readdata,
  input  logic              play_sdram_finished,
  output logic              play_audio_valid,
  output logic [DATA_W-1:0] play_audio_data,
  input  logic              play_audio_ready
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ABORT} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   start_addr_q;
  logic [LEN_W-1:0]    target_q;
  logic [LEN_W-1:0]    fetch_cnt_q;
  logic                dbl_q;
  logic                half_q;
  logic                rep_q;
  logic                read_q;
  logic                done_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic [PTR_W:0]      count_d;
  logic                loop_active;
  logic [LEN_W-1:0]    start_target;
  logic [ADDR_W-1:0]   step;
  logic                fetch_left;
  logic                accept;
  logic                push;
  logic                pop;
  logic                issue;

`ifdef PLAY_LOOP_EN
  logic loop_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      loop_q <= 1'b0;
    end else if (state_q == S_IDLE && play_start) begin
      loop_q <= play_loop;
    end
  end
  assign loop_active = loop_q;
`else
  assign loop_active = 1'b0;
`endif

  // 2x skips every other source word, so only ceil(len/2) fetches are needed
  assign start_target = (play_speed == 2'b01)
                      ? (play_length >> 1) + LEN_W'(play_length[0])
                      : play_length;
  assign step       = dbl_q ? ADDR_W'(2) : ADDR_W'(1);
  assign fetch_left = (fetch_cnt_q != target_q);

  assign play_audio_valid = (state_q == S_RUN) && (count_q != '0) && !play_pause;
  assign play_audio_data  = ((state_q == S_RUN) && (count_q != '0)) ? mem_q[rd_ptr_q] : '0;
  assign play_done        = done_q;
  assign play_busy        = (state_q != S_IDLE);
  assign play_read        = read_q;
  assign play_addr        = addr_q;

  assign accept = play_audio_valid && play_audio_ready;
  assign pop    = accept && (!half_q || rep_q);
  assign push   = (state_q == S_RUN) && read_q && play_sdram_finished;
  assign issue  = (state_q == S_RUN) && !read_q && fetch_left && !play_pause
               && (count_q < FULL_CNT) && !play_stop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= play_readdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      start_addr_q <= '0;
      target_q     <= '0;
      fetch_cnt_q  <= '0;
      dbl_q        <= 1'b0;
      half_q       <= 1'b0;
      rep_q        <= 1'b0;
      read_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (play_start) begin
            addr_q       <= play_select;
            start_addr_q <= play_select;
            target_q     <= start_target;
            fetch_cnt_q  <= '0;
            dbl_q        <= (play_speed == 2'b01);
            half_q       <= (play_speed == 2'b10);
            rep_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            // an empty clip finishes immediately without touching SDRAM
            if (start_target == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (play_stop) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rep_q    <= 1'b0;
            if (read_q && !play_sdram_finished) begin
              state_q <= S_ABORT;
            end else begin
              read_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            if (push) begin
              wr_ptr_q    <= wr_ptr_q + 1'b1;
              addr_q      <= addr_q + step;
              fetch_cnt_q <= fetch_cnt_q + 1'b1;
              read_q      <= 1'b0;
            end else if (issue) begin
              read_q <= 1'b1;
            end
            if (pop) begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept) begin
              rep_q <= half_q && !rep_q;
            end
            count_q <= count_d;
            // looping reloads as soon as fetching is done so the FIFO bridges the seam
            if (!fetch_left && !read_q) begin
              if (loop_active) begin
                addr_q      <= start_addr_q;
                fetch_cnt_q <= '0;
              end else if (count_q == '0) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_ABORT: begin
          if (play_sdram_finished) begin
            read_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_play_stream_engine.sv
// Self-checking bench for play_stream_engine: vector table of clips plus hand-written pause/stop/reset sequences.
module tb_play_stream_engine;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 23;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              play_start;
  logic [ADDR_W-1:0] play_select;
  logic [LEN_W-1:0]  play_length;
  logic [1:0]        play_speed;
  logic              play_pause;
  logic              play_stop;
  logic              play_done;
  logic              play_busy;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] sd_data;
  logic              sd_fin;
  logic              play_audio_valid;
  logic [DATA_W-1:0] play_audio_data;
  logic              play_audio_ready;

  play_stream_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .play_start(play_start), .play_select(play_select), .play_length(play_length),
    .play_speed(play_speed), .play_pause(play_pause), .play_stop(play_stop),
    .play_done(play_done), .play_busy(play_busy), .play_read(play_read), .play_addr(play_addr),
    .play_readdata(sd_data), .play_sdram_finished(sd_fin),
    .play_audio_valid(play_audio_valid), .play_audio_data(play_audio_data),
    .play_audio_ready(play_audio_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    return ({9'd0, a} * 32'h9E3779B1) + 32'h0BAD0000;
  endfunction

  // SDRAM model: completion strobe three cycles after the request is seen
  int sd_wait;
  always @(posedge clk) begin
    if (!rst_n) begin
      sd_fin  <= 1'b0;
      sd_wait <= 0;
      sd_data <= '0;
    end else if (sd_fin) begin
      sd_fin <= 1'b0;
    end else if (play_read) begin
      if (sd_wait == 2) begin
        sd_fin  <= 1'b1;
        sd_data <= mem_word(play_addr);
        sd_wait <= 0;
      end else begin
        sd_wait <= sd_wait + 1;
      end
    end else begin
      sd_wait <= 0;
    end
  end

  typedef struct {
    logic [22:0] sel;
    logic [22:0] len;
    logic [1:0]  speed;
    int          hold;
    int          exp_reads;
    int          exp_samples;
  } vec_t;

  vec_t        vecs[7];
  logic [22:0] exp_addr_q[$];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rd_cnt = 0;
  int smp_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    exp_addr_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_done_in_budget", 64'(n < bound), 1);
  endtask

  task automatic wait_read_pending(input int bound);
    int n = 0;
    while (!(play_read && !sd_fin) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_read_in_budget", 64'(n < bound), 1);
  endtask

  task automatic push_expect(input logic [22:0] sel, input int reads, input logic [1:0] speed);
    logic [22:0] a;
    for (int i = 0; i < reads; i++) begin
      a = sel + 23'((speed == 2'b01) ? 2 * i : i);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_word(a));
      if (speed == 2'b10) exp_q.push_back(mem_word(a));
    end
  endtask

  task automatic pulse_start(input logic [22:0] sel, input logic [22:0] len, input logic [1:0] speed);
    play_select = sel;
    play_length = len;
    play_speed  = speed;
    play_start  = 1'b1;
    @(posedge clk); #1;
    play_start  = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int r0 = rd_cnt;
    int s0 = smp_cnt;
    int d0 = done_cnt;
    push_expect(v.sel, v.exp_reads, v.speed);
    play_audio_ready = (v.hold == 0);
    pulse_start(v.sel, v.len, v.speed);
    chk("busy_after_start", play_busy, 1);
    if (v.hold > 0) begin
      repeat (v.hold) @(posedge clk);
      #1;
      chk("reads_when_full", 64'(rd_cnt - r0), DEPTH);
      chk("read_idle_when_full", play_read, 0);
      play_audio_ready = 1'b1;
    end
    wait_done(3000);
    $display("clip sel=%h len=%0d speed=%0d reads=%0d samples=%0d", v.sel, v.len, v.speed,
             rd_cnt - r0, smp_cnt - s0);
    chk("read_count", 64'(rd_cnt - r0), 64'(v.exp_reads));
    chk("sample_count", 64'(smp_cnt - s0), 64'(v.exp_samples));
    chk("done_pulses", 64'(done_cnt - d0), 1);
    chk("busy_after_done", play_busy, 0);
    chk("sample_queue_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int r0;
    int d0;
    int pv;
    int n;
    vecs[0] = '{23'h000100, 23'd5,  2'd0, 0,  5,  5};
    vecs[1] = '{23'h000010, 23'd6,  2'd1, 0,  3,  3};
    vecs[2] = '{23'h000020, 23'd3,  2'd2, 0,  3,  6};
    vecs[3] = '{23'h000200, 23'd10, 2'd0, 40, 10, 10};
    vecs[4] = '{23'h7FFFFE, 23'd4,  2'd0, 0,  4,  4};
    vecs[5] = '{23'h000300, 23'd3,  2'd3, 0,  3,  3};
    vecs[6] = '{23'h000040, 23'd7,  2'd1, 0,  4,  4};

    rst_n = 1'b0; play_start = 1'b0; play_select = '0; play_length = '0; play_speed = '0;
    play_pause = 1'b0; play_stop = 1'b0; play_audio_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (play_read && sd_fin) begin
          rd_cnt++;
          if (exp_addr_q.size() == 0) begin
            total++; bad++;
            $display("FAIL read_addr: got %0h want none", play_addr);
          end else begin
            chk("read_addr", play_addr, exp_addr_q.pop_front());
          end
        end
        if (play_audio_valid && play_audio_ready) begin
          smp_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sample: got %0h want none", play_audio_data);
          end else begin
            chk("sample", play_audio_data, exp_q.pop_front());
          end
        end
        if (play_done) begin
          done_cnt++;
          chk("busy_low_with_done", play_busy, 0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", play_busy, 0);
    chk("rst_read", play_read, 0);
    chk("rst_addr", play_addr, 0);
    chk("rst_valid", play_audio_valid, 0);
    chk("rst_data", play_audio_data, 0);
    chk("rst_done", play_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // zero-length clip
    r0 = rd_cnt; d0 = done_cnt;
    pulse_start(23'h000050, 23'd0, 2'd0);
    chk("len0_done", play_done, 1);
    chk("len0_busy", play_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_reads", 64'(rd_cnt - r0), 0);
    chk("len0_done_pulses", 64'(done_cnt - d0), 1);
    $display("len0 reads=%0d done=%0d", rd_cnt - r0, done_cnt - d0);

    // pause with a read outstanding
    d0 = done_cnt;
    push_expect(23'h000400, 8, 2'd0);
    play_audio_ready = 1'b1;
    pulse_start(23'h000400, 23'd8, 2'd0);
    repeat (6) @(posedge clk);
    #1;
    wait_read_pending(100);
    play_pause = 1'b1;
    r0 = rd_cnt; pv = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (play_audio_valid) pv++;
    end
    chk("pause_valid_cycles", 64'(pv), 0);
    chk("pause_reads", 64'(rd_cnt - r0), 1);
    chk("pause_read_low", play_read, 0);
    chk("pause_busy", play_busy, 1);
    play_pause = 1'b0;
    wait_done(3000);
    chk("pause_done_pulses", 64'(done_cnt - d0), 1);
    chk("pause_queue_drained", 64'(exp_q.size()), 0);
    $display("pause reads_during_pause=%0d", rd_cnt - r0);

    // stop with a read outstanding, then an immediate restart
    d0 = done_cnt;
    push_expect(23'h000500, 8, 2'd0);
    pulse_start(23'h000500, 23'd8, 2'd0);
    repeat (8) @(posedge clk);
    #1;
    wait_read_pending(100);
    play_stop = 1'b1;
    @(posedge clk); #1;
    play_stop = 1'b0;
    chk("abort_busy", play_busy, 1);
    chk("abort_read_held", play_read, 1);
    chk("abort_valid", play_audio_valid, 0);
    n = 0;
    while (!sd_fin && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_finish_in_budget", 64'(n < 50), 1);
    @(posedge clk); #1;
    chk("abort_idle", play_busy, 0);
    chk("abort_read_low", play_read, 0);
    chk("abort_no_done", 64'(done_cnt - d0), 0);
    $display("stop abort busy=%0b read=%0b", play_busy, play_read);
    clear_sb();
    run_case('{23'h000600, 23'd2, 2'd0, 0, 2, 2});

    // reset in the middle of a read
    push_expect(23'h000700, 4, 2'd0);
    pulse_start(23'h000700, 23'd4, 2'd0);
    wait_read_pending(100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", play_busy, 0);
    chk("midrst_read", play_read, 0);
    chk("midrst_addr", play_addr, 0);
    chk("midrst_valid", play_audio_valid, 0);
    chk("midrst_data", play_audio_data, 0);
    chk("midrst_done", play_done, 0);
    $display("mid-read reset busy=%0b read=%0b", play_busy, play_read);
    clear_sb();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_case('{23'h000800, 23'd3, 2'd0, 0, 3, 3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/play_stream_engine.md
Name: play_stream_engine

Overview:
- Parametrised successor to the single-word SDRAM audio player.
- Streams a bounded region of SDRAM (start address plus length) to the audio DAC interface through a prefetch FIFO, so the SDRAM read latency is hidden from the audio sink.
- Adds real pause, stop/abort, end-of-clip detection with a done pulse, and 0.5x/1x/2x playback speed.
- Sits between the top-level controller, the SDRAM arbiter read port and the audio output block.

Parameters:
- ADDR_W, 23, SDRAM word-address width.
- DATA_W, 32, audio word width (one stereo sample per word).
- LEN_W, 23, width of the clip length in words.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  synchronous active-low reset.
- play_start  in  1  1-cycle start request; accepted only in IDLE.
- play_select  in  ADDR_W  clip start address; sampled on an accepted start.
- play_length  in  LEN_W  clip length in source words; sampled on an accepted start.
- play_speed  in  2  00=1x, 01=2x, 10=0.5x, 11 treated as 1x; sampled on an accepted start.
- play_pause  in  1  level; high freezes playback.
- play_stop  in  1  1-cycle abort request.
- play_done  out  1  1-cycle pulse after the last sample is accepted.
- play_busy  out  1  high in every state except IDLE.
- play_read  out  1  SDRAM read request; held until play_sdram_finished.
- play_addr  out  ADDR_W  SDRAM read address; stable while play_read is high.
- play_readdata  in  DATA_W  SDRAM data; valid in the cycle play_sdram_finished is high.
- play_sdram_finished  in  1  read completion strobe.
- play_audio_valid  out  1  sample available.
- play_audio_data  out  DATA_W  sample; equals the FIFO head.
- play_audio_ready  in  1  sink accepts the sample when valid and ready are both high.

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE, FIFO emptied, counters zeroed. All outputs are 0: play_done, play_busy, play_read, play_addr, play_audio_valid and play_audio_data. Reset takes effect mid-read; any pending SDRAM completion is ignored.
- States: IDLE, RUN, ABORT.
- IDLE -> RUN on play_start.
  - Latches addr=play_select and speed.
  - Fetch count: len for 1x and 0.5x; ceil(len/2) for 2x.
  - With len=0, emits play_done the next cycle and returns to IDLE; no read is issued.
- Fetch side (RUN):
  - A read is issued when the fetch count is not yet reached, play_pause=0 and FIFO occupancy is below FIFO_DEPTH.
  - play_read rises the cycle after the condition holds and stays high until play_sdram_finished.
  - On finished: push play_readdata, addr += 1 (2x: addr += 2), addr wraps modulo 2^ADDR_W, fetch counter increments, play_read drops for at least 1 cycle.
  - Pause asserted during an outstanding read does not cancel it; the read completes and the word is pushed.
- Output side (RUN):
  - play_audio_valid = FIFO not empty and play_pause=0.
  - Pop on valid and ready. At 0.5x each word is presented twice and popped on its second acceptance.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Valid may drop only when paused or when the FIFO is empty.
- Completion: fetch count reached, FIFO empty and no read outstanding -> play_done=1 for 1 cycle and state goes to IDLE.
- play_stop in RUN:
  - No read outstanding: flush FIFO, go to IDLE the next cycle.
  - Read outstanding: go to ABORT and keep play_read high until finished, then discard the data and go to IDLE.
  - No play_done is emitted on stop. play_stop in IDLE is ignored.
- Priority when events coincide: reset > stop > completion > pause. A start while busy is ignored.
- play_audio_valid is 0 in ABORT and IDLE.

Optional Feature:
- Macro: PLAY_LOOP_EN.
- Defined: adds input play_loop (1 bit, sampled at start). When set, the completion condition instead reloads addr and the fetch counter from the latched start values and stays in RUN, with no play_done pulse. Prefetch across the loop boundary is allowed, so there is no gap at the seam. Stop behaves as above.
- Undefined: the port is absent and every clip ends with play_done.

Test Plan:
- 1x basic: select=0x100, length=5, sink always ready, SDRAM finishes 3 cycles after request -> reads 0x100..0x104 in order, 5 samples equal to memory contents, one play_done pulse, play_busy falls with it.
- 2x and 0.5x: select=0x10, length=6 at 2x -> reads 0x10, 0x12, 0x14 and 3 samples out. At 0.5x, length=3 -> 6 samples, each word repeated back-to-back.
- Backpressure/FIFO full: length=10, ready low for 40 cycles -> exactly FIFO_DEPTH reads complete, then play_read stays 0. After ready rises, all 10 samples arrive in order with none lost or duplicated.
- Pause: pause asserted mid-clip with a read outstanding -> that read completes, valid=0, no new reads. Release -> the stream resumes with the next sample; the total is still length.
- Stop with read outstanding: stop during play_read=1 -> play_read stays high until finished, then 0. IDLE within 1 cycle, no play_done, a new start is accepted immediately.
- Edges: length=0 -> play_done the next cycle, zero reads. Start at 0x7FFFFE with length=4 -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001. Reset asserted mid-read -> all outputs 0 the next cycle.
